pm2: RTL and testbench
======================

PM2 -- requirements
Module: pm2

Interface
REQ-001 Parameter: GATE_INPUTS, default 1, operand isolation enable (1 = internal operand registers load only when in_valid=1; 0 = load every cycle).
REQ-002 The block SHALL use one clock and a synchronous, active-low reset.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-005 a  input  2  unsigned multiplicand.
REQ-006 b  input  2  unsigned multiplier.
REQ-007 in_valid  input  1  a/b qualify this cycle.
REQ-008 c  output  4  registered unsigned product a*b.
REQ-009 out_valid  output  1  c holds a newly computed product this cycle.

Function
REQ-010 c SHALL equal the unsigned product a*b, range 0..9; no truncation or overflow is possible (3*3 = 4'b1001).
REQ-011 The product SHALL be formed as a partial-product array:
- pp00=a0&b0, pp10=a1&b0, pp01=a0&b1, pp11=a1&b1
- c0=pp00
- c1=pp10^pp01, k1=pp10&pp01 (half adder)
- c2=pp11^k1, c3=pp11&k1 (half adder)
REQ-012 Operands SHALL be captured into internal registers on a rising clk edge with in_valid=1; the array SHALL read only the registered operands.
REQ-013 Latency SHALL be 2 clk edges from operand capture to c update: edge N captures a/b, edge N+1 loads c and sets out_valid=1.
REQ-014 Throughput SHALL be one product per cycle; back-to-back in_valid pulses SHALL produce back-to-back out_valid pulses in order.
REQ-015 When in_valid=0 at an edge: with GATE_INPUTS=1, operand registers SHALL hold their value; with GATE_INPUTS=0, they SHALL load a/b anyway. The pipelined valid bit SHALL be cleared in both cases.
REQ-016 When the pipelined valid bit is 0 at an edge, c SHALL hold its previous value and out_valid SHALL be 0.
REQ-017 out_valid SHALL be high for exactly one cycle per accepted operand pair.
REQ-018 Input changes on a/b between edges SHALL have no effect on c. c SHALL have no combinational path from any input.
REQ-019 Any operand value, including 0 and 3 in either position, SHALL be handled identically; the product SHALL be commutative.

Reset
REQ-020 While rst_n=0 at a rising clk edge:
- c SHALL be 4'b0000.
- out_valid SHALL be 0.
- The operand registers and the pipelined valid bit SHALL be cleared.
REQ-021 Reset SHALL take priority over in_valid.
REQ-022 Reset asserted mid-operation SHALL discard any in-flight operand pair; no out_valid SHALL follow for that pair.
REQ-023 The first edge with rst_n=1 and in_valid=1 SHALL capture operands normally.

Verification
REQ-024 a=3, b=3, in_valid=1 for one cycle -> two edges later c=4'b1001 (9), out_valid=1 for one cycle.
REQ-025 Back-to-back operand pairs (3,1), (2,1), (2,2) on consecutive cycles -> c=3, 2, 4 on consecutive cycles, out_valid held high for 3 cycles.
REQ-026 All 16 (a,b) combinations streamed back-to-back -> every c equals a*b and matches the swapped operand pair.
REQ-027 in_valid=0 while a/b toggle, GATE_INPUTS=1 -> c unchanged, out_valid=0, operand registers static.
REQ-028 rst_n=0 one cycle after capturing (3,3) -> c=0, out_valid=0, and no 9 is output afterwards.
REQ-029 Reset held low with in_valid=1 -> c stays 0 and out_valid stays 0 until after reset releases.

Source files
------------

// File: rtl/pm2.sv
// PM2: two-stage pipelined 2x2 unsigned multiplier.
// Operands are registered, then a partial-product array feeds the c register.
module pm2 #(
   parameter bit GATE_INPUTS = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] a,
   input  logic [1:0] b,
   input  logic       in_valid,
   output logic [3:0] c,
   output logic       out_valid
);

   logic [1:0] a_q;
   logic [1:0] b_q;
   logic       v_q;

   logic pp00, pp10, pp01, pp11;
   logic k1;
   logic [3:0] prod;

   assign pp00 = a_q[0] & b_q[0];
   assign pp10 = a_q[1] & b_q[0];
   assign pp01 = a_q[0] & b_q[1];
   assign pp11 = a_q[1] & b_q[1];

   // two half adders complete the array
   assign k1      = pp10 & pp01;
   assign prod[0] = pp00;
   assign prod[1] = pp10 ^ pp01;
   assign prod[2] = pp11 ^ k1;
   assign prod[3] = pp11 & k1;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_q       <= '0;
         b_q       <= '0;
         v_q       <= 1'b0;
         c         <= '0;
         out_valid <= 1'b0;
      end else begin
         if (in_valid || !GATE_INPUTS) begin
            a_q <= a;
            b_q <= b;
         end
         v_q       <= in_valid;
         out_valid <= v_q;
         if (v_q) begin
            c <= prod;
         end
      end
   end

endmodule

// File: tb/tb_pm2.sv
// Self-checking bench for pm2: directed vector table plus
// streaming and reset corner-case sequences.
module tb_pm2;

   logic       clk;
   logic       rst_n;
   logic [1:0] a;
   logic [1:0] b;
   logic       in_valid;
   logic [3:0] c;
   logic       out_valid;

   int total;
   int bad;

   typedef struct {
      logic [1:0] a;
      logic [1:0] b;
      logic       v;
      logic [3:0] c;
      logic       ov;
   } vec_t;

   vec_t tbl[12];
   logic [3:0] res[4][4];

   pm2 #(.GATE_INPUTS(1'b1)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .a(a),
      .b(b),
      .in_valid(in_valid),
      .c(c),
      .out_valid(out_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step(input logic [1:0] ta, input logic [1:0] tb,
                       input logic tv);
      @(negedge clk);
      a        = ta;
      b        = tb;
      in_valid = tv;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int got, input int exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic chk_out(input string name, input logic [3:0] ec,
                          input logic eov);
      chk({name, ".c"}, int'(c), int'(ec));
      chk({name, ".ov"}, int'(out_valid), int'(eov));
   endtask

   initial begin
      total    = 0;
      bad      = 0;
      rst_n    = 1'b0;
      a        = 2'd0;
      b        = 2'd0;
      in_valid = 1'b0;

      tbl[0]  = '{a: 2'd3, b: 2'd3, v: 1'b1, c: 4'd0, ov: 1'b0};
      tbl[1]  = '{a: 2'd0, b: 2'd0, v: 1'b0, c: 4'd9, ov: 1'b1};
      tbl[2]  = '{a: 2'd3, b: 2'd1, v: 1'b1, c: 4'd9, ov: 1'b0};
      tbl[3]  = '{a: 2'd2, b: 2'd1, v: 1'b1, c: 4'd3, ov: 1'b1};
      tbl[4]  = '{a: 2'd2, b: 2'd2, v: 1'b1, c: 4'd2, ov: 1'b1};
      tbl[5]  = '{a: 2'd1, b: 2'd3, v: 1'b0, c: 4'd4, ov: 1'b1};
      tbl[6]  = '{a: 2'd2, b: 2'd3, v: 1'b0, c: 4'd4, ov: 1'b0};
      tbl[7]  = '{a: 2'd1, b: 2'd1, v: 1'b0, c: 4'd4, ov: 1'b0};
      tbl[8]  = '{a: 2'd0, b: 2'd3, v: 1'b1, c: 4'd4, ov: 1'b0};
      tbl[9]  = '{a: 2'd3, b: 2'd0, v: 1'b1, c: 4'd0, ov: 1'b1};
      tbl[10] = '{a: 2'd0, b: 2'd0, v: 1'b0, c: 4'd0, ov: 1'b1};
      tbl[11] = '{a: 2'd0, b: 2'd0, v: 1'b0, c: 4'd0, ov: 1'b0};

      step(2'd3, 2'd3, 1'b1);
      step(2'd3, 2'd3, 1'b1);
      chk_out("reset", 4'd0, 1'b0);
      rst_n = 1'b1;

      for (int i = 0; i < 12; i++) begin
         step(tbl[i].a, tbl[i].b, tbl[i].v);
         chk_out($sformatf("vec%0d", i), tbl[i].c, tbl[i].ov);
         if (i == 7) begin
            chk("gate.a_q", int'(dut.a_q), 2);
            chk("gate.b_q", int'(dut.b_q), 2);
         end
      end

      // all 16 pairs streamed back-to-back
      for (int i = 0; i < 17; i++) begin
         if (i < 16) step(2'(i >> 2), 2'(i & 3), 1'b1);
         else step(2'd0, 2'd0, 1'b0);
         if (i > 0) begin
            chk_out($sformatf("stream%0d", i - 1),
                    4'((((i - 1) >> 2) * ((i - 1) & 3))), 1'b1);
            res[(i - 1) >> 2][(i - 1) & 3] = c;
         end
      end
      for (int x = 0; x < 4; x++)
         for (int y = x + 1; y < 4; y++)
            chk($sformatf("commute%0d%0d", x, y),
                int'(res[x][y]), int'(res[y][x]));

      // reset one cycle after capturing (3,3); c is 9 here
      step(2'd3, 2'd3, 1'b1);
      chk_out("pre_rst", 4'd9, 1'b0);
      rst_n = 1'b0;
      step(2'd0, 2'd0, 1'b0);
      chk_out("mid_rst", 4'd0, 1'b0);
      rst_n = 1'b1;
      step(2'd0, 2'd0, 1'b0);
      chk_out("post_rst0", 4'd0, 1'b0);
      step(2'd0, 2'd0, 1'b0);
      chk_out("post_rst1", 4'd0, 1'b0);

      // reset held with in_valid high
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step(2'd3, 2'd2, 1'b1);
         chk_out($sformatf("rst_hold%0d", i), 4'd0, 1'b0);
      end
      rst_n = 1'b1;
      step(2'd2, 2'd3, 1'b1);
      chk_out("rel0", 4'd0, 1'b0);
      step(2'd1, 2'd1, 1'b0);
      chk_out("rel1", 4'd6, 1'b1);
      step(2'd1, 2'd1, 1'b0);
      chk_out("rel2", 4'd6, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
